// File: rtl/regfl_2r1w_param_pkg.sv
// -----------------------------------------------------------------------------
// regfl_2r1w_param_pkg
// Shared definitions for the 2-read/1-write register file:
//   - clr_state_e : clear-sequencer state encoding (ST_IDLE=1'b0, ST_CLEAR=1'b1)
//   - REGFL_DEF_DATA_W / REGFL_DEF_DEPTH : default geometry
//   - regfl_addr_w() : address width for a given entry count (minimum 1 bit)
// No ports.
// -----------------------------------------------------------------------------
package regfl_2r1w_param_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int REGFL_DEF_DATA_W = 8;
  localparam int REGFL_DEF_DEPTH  = 4;

  // Address width needed to index 'depth' entries; never narrower than 1 bit.
  function automatic int regfl_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfl_entry.sv
// -----------------------------------------------------------------------------
// regfl_entry
// One register-file word plus its valid bit.
// Ports:
//   clk    in   1       rising-edge clock
//   rst_b  in   1       asynchronous active-low reset (word 0, valid 0)
//   clr    in   1       synchronous clear (word 0, valid 0); wins over ld
//   ld     in   1       load d, set valid
//   d      in   DATA_W  load data
//   q      out  DATA_W  stored word
//   vld    out  1       word has been loaded since last reset/clear
// -----------------------------------------------------------------------------
module regfl_entry
  import regfl_2r1w_param_pkg::*;
#(
  parameter int DATA_W = REGFL_DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              vld
);

  // Storage word and valid flag; clear takes priority so a sweep always wins.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (ld) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/regfl_2r1w_param.sv
// -----------------------------------------------------------------------------
// regfl_2r1w_param
// Parametrised register file: one write port, two combinational read ports,
// per-entry valid bits and a sequenced clear (one entry per cycle) that
// holds 'busy' high for exactly DEPTH cycles and rejects writes meanwhile.
//
// Optional feature macro: REGFL_BYPASS_EN
//   defined   : an accepted write is forwarded to a read port addressing the
//               same entry in the same cycle.
//   undefined : reads show stored contents only.
//
// Ports:
//   clk       in   1       rising-edge clock
//   rst_b     in   1       asynchronous active-low reset
//   wr_e      in   1       write request
//   wr_addr   in   ADDR_W  write address
//   wr_data   in   DATA_W  write data
//   rd0_addr  in   ADDR_W  read port 0 address
//   rd0_data  out  DATA_W  read port 0 data (combinational)
//   rd0_vld   out  1       read port 0 entry valid
//   rd1_addr  in   ADDR_W  read port 1 address
//   rd1_data  out  DATA_W  read port 1 data (combinational)
//   rd1_vld   out  1       read port 1 entry valid
//   clr_req   in   1       request a sequenced clear
//   busy      out  1       clear in progress (registered)
//   wr_rej    out  1       registered pulse: previous-cycle write was rejected
// -----------------------------------------------------------------------------
module regfl_2r1w_param
  import regfl_2r1w_param_pkg::*;
#(
  parameter int DATA_W = REGFL_DEF_DATA_W,
  parameter int DEPTH  = REGFL_DEF_DEPTH,
  parameter int ADDR_W = regfl_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr_e,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_vld,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_vld,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_rej
);

  // DEPTH widened by one bit so out-of-range addresses compare cleanly even
  // when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_LIM = DEPTH[ADDR_W:0];
  localparam int                LAST_I    = DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST_PTR  = LAST_I[ADDR_W-1:0];

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;

  logic              wr_in_range;
  logic              wr_ok;
  logic [DEPTH-1:0]  ld_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;

  logic [DATA_W-1:0] mux0_data;
  logic              mux0_vld;
  logic [DATA_W-1:0] mux1_data;
  logic              mux1_vld;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign wr_ok       = wr_e & ~busy & wr_in_range;

  // Entry array: write decode and clear-pointer decode per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign ld_vec[gi]  = wr_ok && (wr_addr == ADDR_W'(gi));
    assign clr_vec[gi] = (state == ST_CLEAR) && (clr_ptr == ADDR_W'(gi));

    regfl_entry #(
      .DATA_W (DATA_W)
    ) u_entry (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (clr_vec[gi]),
      .ld    (ld_vec[gi]),
      .d     (wr_data),
      .q     (ent_data[gi]),
      .vld   (ent_vld[gi])
    );
  end

  // Read port 0 AND-OR mux; an out-of-range address matches nothing and reads 0.
  always_comb begin
    mux0_data = '0;
    mux0_vld  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mux0_data = mux0_data | (ent_data[i] & {DATA_W{rd0_addr == ADDR_W'(i)}});
      mux0_vld  = mux0_vld  | (ent_vld[i]  &        (rd0_addr == ADDR_W'(i)));
    end
  end

  // Read port 1 AND-OR mux, same structure as port 0.
  always_comb begin
    mux1_data = '0;
    mux1_vld  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mux1_data = mux1_data | (ent_data[i] & {DATA_W{rd1_addr == ADDR_W'(i)}});
      mux1_vld  = mux1_vld  | (ent_vld[i]  &        (rd1_addr == ADDR_W'(i)));
    end
  end

`ifdef REGFL_BYPASS_EN
  // Read outputs with same-cycle forwarding of an accepted write only.
  always_comb begin
    rd0_data = mux0_data;
    rd0_vld  = mux0_vld;
    rd1_data = mux1_data;
    rd1_vld  = mux1_vld;
    if (wr_ok && (rd0_addr == wr_addr)) begin
      rd0_data = wr_data;
      rd0_vld  = 1'b1;
    end else begin
      rd0_data = mux0_data;
      rd0_vld  = mux0_vld;
    end
    if (wr_ok && (rd1_addr == wr_addr)) begin
      rd1_data = wr_data;
      rd1_vld  = 1'b1;
    end else begin
      rd1_data = mux1_data;
      rd1_vld  = mux1_vld;
    end
  end
`else
  // Read outputs show stored contents only.
  always_comb begin
    rd0_data = mux0_data;
    rd0_vld  = mux0_vld;
    rd1_data = mux1_data;
    rd1_vld  = mux1_vld;
  end
`endif

  // Clear sequencer next state: IDLE arms on clr_req, CLEAR walks 0..DEPTH-1
  // once and ignores clr_req while walking.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end else begin
          state_nxt   = ST_IDLE;
          clr_ptr_nxt = clr_ptr;
        end
      end
      ST_CLEAR: begin
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = ST_IDLE;
          clr_ptr_nxt = '0;
        end else begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Sequencer registers; busy is loaded from the next state so it tracks
  // state==CLEAR exactly, without a combinational path to the output.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      busy    <= (state_nxt == ST_CLEAR);
    end
  end

  // Rejection flag: a requested write that was not accepted this cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_rej <= 1'b0;
    end else begin
      wr_rej <= wr_e & ~wr_ok;
    end
  end

endmodule

// File: tb/tb_regfl_2r1w_param.sv
// -----------------------------------------------------------------------------
// tb_regfl_2r1w_param
// Directed bench for regfl_2r1w_param: a DEPTH=4 instance (main checks) and a
// DEPTH=5 instance (non-power-of-two range checks). Expected values are
// hand-computed constants and a small shadow of the entry contents.
// -----------------------------------------------------------------------------
module tb_regfl_2r1w_param;

  logic       clk;
  logic       rst_b;

  // DEPTH=4 instance
  logic       wr_e;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd0_addr;
  logic [7:0] rd0_data;
  logic       rd0_vld;
  logic [1:0] rd1_addr;
  logic [7:0] rd1_data;
  logic       rd1_vld;
  logic       clr_req;
  logic       busy;
  logic       wr_rej;

  // DEPTH=5 instance
  logic       b_wr_e;
  logic [2:0] b_wr_addr;
  logic [7:0] b_wr_data;
  logic [2:0] b_rd0_addr;
  logic [7:0] b_rd0_data;
  logic       b_rd0_vld;
  logic [2:0] b_rd1_addr;
  logic [7:0] b_rd1_data;
  logic       b_rd1_vld;
  logic       b_clr_req;
  logic       b_busy;
  logic       b_wr_rej;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_d [4];
  logic       exp_v [4];

  regfl_2r1w_param #(.DATA_W(8), .DEPTH(4)) u_dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .wr_e     (wr_e),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd0_vld  (rd0_vld),
    .rd1_addr (rd1_addr),
    .rd1_data (rd1_data),
    .rd1_vld  (rd1_vld),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_rej   (wr_rej)
  );

  regfl_2r1w_param #(.DATA_W(8), .DEPTH(5)) u_dut5 (
    .clk      (clk),
    .rst_b    (rst_b),
    .wr_e     (b_wr_e),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .rd0_addr (b_rd0_addr),
    .rd0_data (b_rd0_data),
    .rd0_vld  (b_rd0_vld),
    .rd1_addr (b_rd1_addr),
    .rd1_data (b_rd1_data),
    .rd1_vld  (b_rd1_vld),
    .clr_req  (b_clr_req),
    .busy     (b_busy),
    .wr_rej   (b_wr_rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_e    = 1'b1;
    tick();
    wr_e    = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [7:0] d);
    b_wr_addr = a;
    b_wr_data = d;
    b_wr_e    = 1'b1;
    tick();
    b_wr_e    = 1'b0;
  endtask

  initial begin
    rst_b      = 1'b0;
    wr_e       = 1'b0;
    wr_addr    = 2'd0;
    wr_data    = 8'h00;
    rd0_addr   = 2'd0;
    rd1_addr   = 2'd0;
    clr_req    = 1'b0;
    b_wr_e     = 1'b0;
    b_wr_addr  = 3'd0;
    b_wr_data  = 8'h00;
    b_rd0_addr = 3'd0;
    b_rd1_addr = 3'd0;
    b_clr_req  = 1'b0;

    // Reset state
    #2;
    chk("rst_busy",   32'(busy),     32'h0);
    chk("rst_wr_rej", 32'(wr_rej),   32'h0);
    chk("rst_rd0",    32'(rd0_data), 32'h00);
    chk("rst_rd0_v",  32'(rd0_vld),  32'h0);
    chk("rst_b_rd0_v", 32'(b_rd0_vld), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;

    // Write A2@0, read ports on 0 and 3
    wr_a(2'd0, 8'hA2);
    rd0_addr = 2'd0;
    rd1_addr = 2'd3;
    #1;
    chk("wr0_rd0",   32'(rd0_data), 32'hA2);
    chk("wr0_rd0_v", 32'(rd0_vld),  32'h1);
    chk("wr0_rd1",   32'(rd1_data), 32'h00);
    chk("wr0_rd1_v", 32'(rd1_vld),  32'h0);
    chk("wr0_rej",   32'(wr_rej),   32'h0);

    // Both ports on one entry, then on different entries
    wr_a(2'd2, 8'h2E);
    wr_a(2'd1, 8'h98);
    rd0_addr = 2'd2;
    rd1_addr = 2'd2;
    #1;
    chk("same_rd0", 32'({rd0_vld, rd0_data}), 32'h12E);
    chk("same_rd1", 32'({rd1_vld, rd1_data}), 32'h12E);
    rd0_addr = 2'd1;
    #1;
    chk("diff_rd0", 32'({rd0_vld, rd0_data}), 32'h198);
    chk("diff_rd1", 32'({rd1_vld, rd1_data}), 32'h12E);

    // Same-cycle write and read of entry 3
    wr_addr  = 2'd3;
    wr_data  = 8'h55;
    wr_e     = 1'b1;
    rd0_addr = 2'd3;
    #1;
`ifdef REGFL_BYPASS_EN
    chk("byp_same", 32'({rd0_vld, rd0_data}), 32'h155);
`else
    chk("byp_same", 32'({rd0_vld, rd0_data}), 32'h000);
`endif
    tick();
    wr_e = 1'b0;
    #1;
    chk("byp_next", 32'({rd0_vld, rd0_data}), 32'h155);

    // Sequenced clear over a full file; reject a write mid-sweep, and a
    // clr_req during the sweep must not extend it.
    exp_d[0] = 8'hA2; exp_d[1] = 8'h98; exp_d[2] = 8'h2E; exp_d[3] = 8'h55;
    exp_v[0] = 1'b1;  exp_v[1] = 1'b1;  exp_v[2] = 1'b1;  exp_v[3] = 1'b1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd0_addr = 2'(k);
      rd1_addr = 2'((k + 1) % 4);
      wr_e     = (k == 1);
      wr_addr  = 2'd1;
      wr_data  = 8'hFF;
      clr_req  = (k == 2);
      #1;
      chk($sformatf("clr%0d_busy", k), 32'(busy), 32'h1);
      chk($sformatf("clr%0d_pre", k), 32'({rd0_vld, rd0_data}), 32'({exp_v[k], exp_d[k]}));
      tick();
      wr_e    = 1'b0;
      clr_req = 1'b0;
      exp_d[k] = 8'h00;
      exp_v[k] = 1'b0;
      #1;
      chk($sformatf("clr%0d_post", k), 32'({rd0_vld, rd0_data}), 32'h000);
      if (k < 3) begin
        chk($sformatf("clr%0d_unswept", k), 32'({rd1_vld, rd1_data}),
            32'({exp_v[k + 1], exp_d[k + 1]}));
      end else begin
        chk($sformatf("clr%0d_swept", k), 32'({rd1_vld, rd1_data}), 32'h000);
      end
      chk($sformatf("clr%0d_rej", k), 32'(wr_rej), (k == 1) ? 32'h1 : 32'h0);
    end
    chk("clr_done_busy", 32'(busy), 32'h0);
    tick();
    chk("clr_noext_busy", 32'(busy), 32'h0);
    rd0_addr = 2'd1;
    #1;
    chk("clr_rej_entry1", 32'({rd0_vld, rd0_data}), 32'h000);

    // clr_req and write in the same IDLE cycle: write lands, then sweep erases it
    wr_addr  = 2'd2;
    wr_data  = 8'h77;
    wr_e     = 1'b1;
    clr_req  = 1'b1;
    tick();
    wr_e     = 1'b0;
    clr_req  = 1'b0;
    rd0_addr = 2'd2;
    #1;
    chk("wrclr_data", 32'({rd0_vld, rd0_data}), 32'h177);
    chk("wrclr_rej",  32'(wr_rej), 32'h0);
    chk("wrclr_busy", 32'(busy),   32'h1);
    tick(); tick(); tick(); tick();
    chk("wrclr_end_busy", 32'(busy), 32'h0);
    chk("wrclr_erased", 32'({rd0_vld, rd0_data}), 32'h000);

    // Reset during the second clear cycle
    wr_a(2'd0, 8'h11);
    wr_a(2'd1, 8'h22);
    wr_a(2'd2, 8'h33);
    wr_a(2'd3, 8'h44);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'h1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy),   32'h0);
    chk("mid_rst_rej",  32'(wr_rej), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd0_addr = 2'(a);
      #1;
      chk($sformatf("mid_rst_e%0d", a), 32'({rd0_vld, rd0_data}), 32'h000);
    end
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'h0);
    wr_a(2'd3, 8'h66);
    rd0_addr = 2'd3;
    #1;
    chk("post_rst_wr",  32'({rd0_vld, rd0_data}), 32'h166);
    chk("post_rst_rej", 32'(wr_rej), 32'h0);

    // DEPTH=5 instance: out-of-range write and read
    wr_b(3'd4, 8'h5A);
    b_rd0_addr = 3'd4;
    #1;
    chk("d5_wr4",     32'({b_rd0_vld, b_rd0_data}), 32'h15A);
    chk("d5_wr4_rej", 32'(b_wr_rej), 32'h0);
    wr_b(3'd6, 8'hC7);
    chk("d5_wr6_rej", 32'(b_wr_rej), 32'h1);
    chk("d5_e4_keep", 32'({b_rd0_vld, b_rd0_data}), 32'h15A);
    for (int a = 0; a < 4; a++) begin
      b_rd1_addr = 3'(a);
      #1;
      chk($sformatf("d5_e%0d_keep", a), 32'({b_rd1_vld, b_rd1_data}), 32'h000);
    end
    b_rd0_addr = 3'd7;
    b_rd1_addr = 3'd6;
    #1;
    chk("d5_rd7", 32'({b_rd0_vld, b_rd0_data}), 32'h000);
    chk("d5_rd6", 32'({b_rd1_vld, b_rd1_data}), 32'h000);
    tick();
    chk("d5_rej_clear", 32'(b_wr_rej), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
